// File: rtl/mul_div_seq_if.sv
// Control bundle between the multiply/divide sequencer and the EBOX data path.
interface mul_div_seq_if;
  logic       start;
  logic       opDiv;
  logic       MQ34;
  logic       MQ35;
  logic       ADcarryM2;
  logic [6:0] adFunc;
  logic       adaEn;
  logic [1:0] adaSel;
  logic [1:0] adbSel;
  logic [2:0] arlSel;
  logic [2:0] arrSel;
  logic       arLoad;
  logic [2:0] arxSel;
  logic       arxLoad;
  logic [1:0] mqSel;
  logic [1:0] mqmSel;
  logic       mqmEn;
  logic       busy;
  logic       done;
  logic       divOverflow;
  logic [5:0] stepCnt;

  modport master (
    output start, opDiv, MQ34, MQ35, ADcarryM2,
    input  adFunc, adaEn, adaSel, adbSel, arlSel, arrSel, arLoad, arxSel, arxLoad,
           mqSel, mqmSel, mqmEn, busy, done, divOverflow, stepCnt
  );

  modport slave (
    input  start, opDiv, MQ34, MQ35, ADcarryM2,
    output adFunc, adaEn, adaSel, adbSel, arlSel, arrSel, arLoad, arxSel, arxLoad,
           mqSel, mqmSel, mqmEn, busy, done, divOverflow, stepCnt
  );
endinterface

// File: rtl/mul_div_seq.sv
// Radix-4 Booth multiply / non-restoring divide step sequencer for the EBOX data path.
module mul_div_seq #(
  parameter int unsigned MUL_STEPS = 18,
  parameter int unsigned DIV_STEPS = 36
) (
  input  logic          eboxClk,
  input  logic          eboxReset_n,
  mul_div_seq_if.slave  ctl
);

  localparam int unsigned CNT_W = 6;

  localparam logic [6:0] AD_A     = 7'o37;
  localparam logic [6:0] AD_APB   = 7'o06;
  localparam logic [6:0] AD_AMB   = 7'o51;
  localparam logic [6:0] AD_ZERO  = 7'o34;
  localparam logic [1:0] ADB_BR2  = 2'b01;
  localparam logic [1:0] ADB_BR   = 2'b10;
  localparam logic [2:0] SEL_AD   = 3'b010;
  localparam logic [2:0] SEL_AD2  = 3'b101;
  localparam logic [2:0] SEL_AD4  = 3'b111;
  localparam logic [1:0] MQ_LOAD  = 2'b00;
  localparam logic [1:0] MQ_SHL   = 2'b01;
  localparam logic [1:0] MQ_HOLD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_MSTEP,
    S_DSTEP,
    S_DFIX,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic               cbit_q, cbit_d;
  logic               qbit_q, qbit_d;
  logic               op_div_q, op_div_d;
  logic               div_ovf_q, div_ovf_d;

  // State and datapath-sequencing registers.
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      state_q    <= S_IDLE;
      step_cnt_q <= '0;
      cbit_q     <= 1'b0;
      qbit_q     <= 1'b0;
      op_div_q   <= 1'b0;
      div_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      cbit_q     <= cbit_d;
      qbit_q     <= qbit_d;
      op_div_q   <= op_div_d;
      div_ovf_q  <= div_ovf_d;
    end
  end

  // Next-state and data-path control decode; idle codes are the defaults.
  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    cbit_d         = cbit_q;
    qbit_d         = qbit_q;
    op_div_d       = op_div_q;
    div_ovf_d      = div_ovf_q;

    ctl.adFunc     = AD_A;
    ctl.adaEn      = 1'b0;
    ctl.adaSel     = 2'b00;
    ctl.adbSel     = ADB_BR;
    ctl.arlSel     = SEL_AD;
    ctl.arrSel     = SEL_AD;
    ctl.arLoad     = 1'b0;
    ctl.arxSel     = SEL_AD;
    ctl.arxLoad    = 1'b0;
    ctl.mqSel      = MQ_HOLD;
    ctl.mqmSel     = 2'b00;
    ctl.mqmEn      = 1'b0;
    ctl.busy       = (state_q != S_IDLE);
    ctl.done       = 1'b0;
    ctl.divOverflow = div_ovf_q;
    ctl.stepCnt    = step_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          op_div_d  = ctl.opDiv;
          div_ovf_d = 1'b0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (!op_div_q) begin
          // Clear AR so the Booth accumulation starts from zero.
          ctl.adFunc = AD_ZERO;
          ctl.arLoad = 1'b1;
          cbit_d     = 1'b0;
          step_cnt_d = CNT_W'(MUL_STEPS);
          state_d    = S_MSTEP;
        end else begin
          // Trial subtract only: a carry means the quotient cannot fit.
          ctl.adaEn  = 1'b1;
          ctl.adbSel = ADB_BR;
          ctl.adFunc = AD_AMB;
          if (ctl.ADcarryM2) begin
            div_ovf_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            step_cnt_d = CNT_W'(DIV_STEPS);
            qbit_d     = 1'b1;
            state_d    = S_DSTEP;
          end
        end
      end

      S_MSTEP: begin
        case ({ctl.MQ34, ctl.MQ35, cbit_q})
          3'b001, 3'b010: begin ctl.adFunc = AD_APB; ctl.adbSel = ADB_BR;  end
          3'b011:         begin ctl.adFunc = AD_APB; ctl.adbSel = ADB_BR2; end
          3'b100:         begin ctl.adFunc = AD_AMB; ctl.adbSel = ADB_BR2; end
          3'b101, 3'b110: begin ctl.adFunc = AD_AMB; ctl.adbSel = ADB_BR;  end
          default:        begin ctl.adFunc = AD_A;   ctl.adbSel = ADB_BR;  end
        endcase
        ctl.adaEn  = 1'b1;
        ctl.arLoad = 1'b1;
        ctl.arlSel = SEL_AD4;
        ctl.arrSel = SEL_AD4;
        ctl.mqSel  = MQ_LOAD;
        ctl.mqmEn  = 1'b1;
        cbit_d     = ctl.MQ34;
        step_cnt_d = step_cnt_q - CNT_W'(1);
        if (step_cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DSTEP: begin
        ctl.adFunc = qbit_q ? AD_AMB : AD_APB;
        ctl.adbSel = ADB_BR;
        ctl.adaEn  = 1'b1;
        ctl.arLoad = 1'b1;
        ctl.mqSel  = MQ_SHL;
        qbit_d     = ctl.ADcarryM2;
        step_cnt_d = step_cnt_q - CNT_W'(1);
        if (step_cnt_q == CNT_W'(1)) begin
          // Last step keeps the remainder unshifted.
          state_d = S_DFIX;
        end else begin
          ctl.arlSel  = SEL_AD2;
          ctl.arrSel  = SEL_AD2;
          ctl.arxSel  = SEL_AD2;
          ctl.arxLoad = 1'b1;
        end
      end

      S_DFIX: begin
        // A negative partial remainder is restored by adding BR back.
        if (!qbit_q) begin
          ctl.adaEn  = 1'b1;
          ctl.adFunc = AD_APB;
          ctl.adbSel = ADB_BR;
          ctl.arLoad = 1'b1;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        ctl.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for the multiply/divide step sequencer.
module tb_mul_div_seq;

  localparam int unsigned MUL_STEPS = 18;
  localparam int unsigned DIV_STEPS = 36;
  localparam int MUL_LAT = 20;
  localparam int DIV_LAT = 39;
  localparam int OVF_LAT = 2;
  localparam int MAX_CYC = 200;

  localparam logic [27:0] IDLE_VEC = {7'o37, 1'b0, 2'b00, 2'b10, 3'b010, 3'b010,
                                      1'b0, 3'b010, 1'b0, 2'b11, 2'b00, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul_div_seq_if bus ();

  mul_div_seq #(.MUL_STEPS(MUL_STEPS), .DIV_STEPS(DIV_STEPS)) dut (
    .eboxClk     (clk),
    .eboxReset_n (rst_n),
    .ctl         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   lat;
    logic ovf;
  } exp_t;

  exp_t sb[$];

  function automatic logic [27:0] ctl_vec();
    return {bus.adFunc, bus.adaEn, bus.adaSel, bus.adbSel, bus.arlSel, bus.arrSel,
            bus.arLoad, bus.arxSel, bus.arxLoad, bus.mqSel, bus.mqmSel, bus.mqmEn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue a start in IDLE and record the expected completion; returns in cycle 1.
  task automatic start_op(input logic div, input int l, input logic o);
    exp_t e;
    e = '{l, o};
    bus.start = 1'b1;
    bus.opDiv = div;
    sb.push_back(e);
    tick();
    bus.start = 1'b0;
    bus.opDiv = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else e = '{0, 1'b0};
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.opDiv = 1'b0;
    bus.MQ34 = 1'b0; bus.MQ35 = 1'b0; bus.ADcarryM2 = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    n_checks++; if (bus.stepCnt !== 6'd0) begin n_fail++; $display("FAIL reset_stepcnt: got %0d expected 0", bus.stepCnt); end
    n_checks++; if (bus.divOverflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", bus.divOverflow); end
    n_checks++; if (ctl_vec() !== IDLE_VEC) begin n_fail++; $display("FAIL reset_codes: got %h expected %h", ctl_vec(), IDLE_VEC); end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0b expected 0", bus.busy); end
  endtask

  task automatic test_multiply();
    exp_t e; bit ok; int cyc; int msteps; logic cb; logic [6:0] ef; logic [1:0] eb;
    start_op(1'b0, MUL_LAT, 1'b0);
    cyc = 1;
    n_checks++;
    if ({bus.adFunc, bus.arLoad, bus.arlSel, bus.arrSel, bus.busy} !== {7'o34, 1'b1, 3'b010, 3'b010, 1'b1}) begin
      n_fail++; $display("FAIL mul_setup: got f=%o ld=%b busy=%b expected f=34 ld=1 busy=1", bus.adFunc, bus.arLoad, bus.busy);
    end
    tick(); cyc = 2; cb = 1'b0; msteps = 0;
    while (bus.done !== 1'b1 && cyc < MAX_CYC) begin
      bus.MQ34 = 1'($urandom_range(0, 1));
      bus.MQ35 = 1'($urandom_range(0, 1));
      #1;
      case ({bus.MQ34, bus.MQ35, cb})
        3'b001, 3'b010: begin ef = 7'o06; eb = 2'b10; end
        3'b011:         begin ef = 7'o06; eb = 2'b01; end
        3'b100:         begin ef = 7'o51; eb = 2'b01; end
        3'b101, 3'b110: begin ef = 7'o51; eb = 2'b10; end
        default:        begin ef = 7'o37; eb = 2'b10; end
      endcase
      n_checks++;
      if ({bus.adFunc, bus.adbSel, bus.arlSel, bus.arrSel, bus.arLoad, bus.mqSel, bus.mqmEn, bus.adaEn}
          !== {ef, eb, 3'b111, 3'b111, 1'b1, 2'b00, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL mstep_decode cyc %0d digit %b%b%b: got f=%o b=%b sel=%o expected f=%o b=%b sel=77",
                 cyc, bus.MQ34, bus.MQ35, cb, bus.adFunc, bus.adbSel, {bus.arlSel, bus.arrSel}, ef, eb);
      end
      n_checks++;
      if (bus.stepCnt !== 6'(MUL_STEPS - msteps)) begin
        n_fail++; $display("FAIL mstep_cnt cyc %0d: got %0d expected %0d", cyc, bus.stepCnt, MUL_STEPS - msteps);
      end
      cb = bus.MQ34; msteps++;
      tick(); cyc++;
    end
    bus.MQ34 = 1'b0; bus.MQ35 = 1'b0;
    pop_exp(e, ok);
    n_checks++; if (!ok || cyc !== e.lat) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", cyc, e.lat); end
    n_checks++; if (bus.divOverflow !== e.ovf) begin n_fail++; $display("FAIL mul_ovf: got %0b expected %0b", bus.divOverflow, e.ovf); end
    n_checks++; if (msteps !== int'(MUL_STEPS)) begin n_fail++; $display("FAIL mul_steps: got %0d expected %0d", msteps, MUL_STEPS); end
    n_checks++; if (ctl_vec() !== IDLE_VEC) begin n_fail++; $display("FAIL mul_done_codes: got %h expected %h", ctl_vec(), IDLE_VEC); end
    tick();
    n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL mul_after_done: got busy/done %b expected 00", {bus.busy, bus.done}); end
  endtask

  task automatic test_booth_decode();
    exp_t e; bit ok; int cyc;
    start_op(1'b0, MUL_LAT, 1'b0);
    tick(); cyc = 2;
    bus.MQ34 = 1'b1; bus.MQ35 = 1'b1; #1;
    n_checks++; if ({bus.adFunc, bus.adbSel} !== {7'o51, 2'b10}) begin n_fail++; $display("FAIL booth_110: got f=%o b=%b expected f=51 b=10", bus.adFunc, bus.adbSel); end
    tick(); cyc++;
    bus.MQ34 = 1'b0; bus.MQ35 = 1'b1; #1;
    n_checks++; if ({bus.adFunc, bus.adbSel} !== {7'o06, 2'b01}) begin n_fail++; $display("FAIL booth_011: got f=%o b=%b expected f=06 b=01", bus.adFunc, bus.adbSel); end
    tick(); cyc++;
    bus.MQ34 = 1'b1; bus.MQ35 = 1'b0; #1;
    n_checks++; if ({bus.adFunc, bus.adbSel} !== {7'o51, 2'b01}) begin n_fail++; $display("FAIL booth_100: got f=%o b=%b expected f=51 b=01", bus.adFunc, bus.adbSel); end
    tick(); cyc++;
    bus.MQ34 = 1'b0; bus.MQ35 = 1'b0; #1;
    n_checks++; if ({bus.adFunc, bus.adbSel} !== {7'o06, 2'b10}) begin n_fail++; $display("FAIL booth_001: got f=%o b=%b expected f=06 b=10", bus.adFunc, bus.adbSel); end
    tick(); cyc++;
    while (bus.done !== 1'b1 && cyc < MAX_CYC) begin tick(); cyc++; end
    pop_exp(e, ok);
    n_checks++; if (!ok || cyc !== e.lat) begin n_fail++; $display("FAIL booth_latency: got %0d expected %0d", cyc, e.lat); end
    tick();
  endtask

  task automatic test_divide(input logic last_carry);
    exp_t e; bit ok; int cyc; int dsteps; logic qb; logic last; logic [2:0] es;
    start_op(1'b1, DIV_LAT, 1'b0);
    cyc = 1;
    bus.ADcarryM2 = 1'b0; #1;
    n_checks++;
    if ({bus.adFunc, bus.adaEn, bus.adbSel, bus.arLoad, bus.arxLoad, bus.mqSel} !== {7'o51, 1'b1, 2'b10, 1'b0, 1'b0, 2'b11}) begin
      n_fail++; $display("FAIL div_setup: got f=%o en=%b ld=%b%b mq=%b expected f=51 en=1 ld=00 mq=11",
                         bus.adFunc, bus.adaEn, bus.arLoad, bus.arxLoad, bus.mqSel);
    end
    tick(); cyc = 2; qb = 1'b1; dsteps = 0;
    while (bus.done !== 1'b1 && cyc < MAX_CYC) begin
      if (dsteps < int'(DIV_STEPS)) begin
        last = (dsteps == int'(DIV_STEPS) - 1);
        bus.ADcarryM2 = last ? last_carry : 1'($urandom_range(0, 1));
        #1;
        es = last ? 3'b010 : 3'b101;
        n_checks++;
        if ({bus.adFunc, bus.adbSel, bus.adaEn, bus.arLoad, bus.mqSel, bus.arlSel, bus.arrSel, bus.arxLoad}
            !== {(qb ? 7'o51 : 7'o06), 2'b10, 1'b1, 1'b1, 2'b01, es, es, ~last}) begin
          n_fail++;
          $display("FAIL dstep cyc %0d: got f=%o sel=%o xld=%b mq=%b expected f=%o sel=%o%o xld=%b mq=01",
                   cyc, bus.adFunc, {bus.arlSel, bus.arrSel}, bus.arxLoad, bus.mqSel, (qb ? 7'o51 : 7'o06), es, es, ~last);
        end
        if (!last) begin
          n_checks++; if (bus.arxSel !== 3'b101) begin n_fail++; $display("FAIL dstep_arxsel cyc %0d: got %b expected 101", cyc, bus.arxSel); end
        end
        n_checks++;
        if (bus.stepCnt !== 6'(DIV_STEPS - dsteps)) begin
          n_fail++; $display("FAIL dstep_cnt cyc %0d: got %0d expected %0d", cyc, bus.stepCnt, DIV_STEPS - dsteps);
        end
        qb = bus.ADcarryM2;
      end else begin
        #1;
        n_checks++;
        if (!qb) begin
          if ({bus.adFunc, bus.adbSel, bus.arLoad, bus.arlSel, bus.arrSel, bus.arxLoad, bus.mqSel}
              !== {7'o06, 2'b10, 1'b1, 3'b010, 3'b010, 1'b0, 2'b11}) begin
            n_fail++; $display("FAIL dfix_restore: got f=%o b=%b ld=%b xld=%b mq=%b expected f=06 b=10 ld=1 xld=0 mq=11",
                               bus.adFunc, bus.adbSel, bus.arLoad, bus.arxLoad, bus.mqSel);
          end
        end else begin
          if ({bus.arLoad, bus.arxLoad, bus.mqSel} !== {1'b0, 1'b0, 2'b11}) begin
            n_fail++; $display("FAIL dfix_hold: got ld=%b xld=%b mq=%b expected ld=0 xld=0 mq=11", bus.arLoad, bus.arxLoad, bus.mqSel);
          end
        end
      end
      dsteps++;
      tick(); cyc++;
    end
    bus.ADcarryM2 = 1'b0;
    pop_exp(e, ok);
    n_checks++; if (!ok || cyc !== e.lat) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", cyc, e.lat); end
    n_checks++; if (bus.divOverflow !== e.ovf) begin n_fail++; $display("FAIL div_ovf: got %0b expected %0b", bus.divOverflow, e.ovf); end
    n_checks++; if (dsteps !== int'(DIV_STEPS) + 1) begin n_fail++; $display("FAIL div_steps: got %0d expected %0d", dsteps, DIV_STEPS + 1); end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL div_after_done: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_div_overflow();
    exp_t e; bit ok; int cyc; bit bad;
    start_op(1'b1, OVF_LAT, 1'b1);
    cyc = 1; bad = 1'b0;
    bus.ADcarryM2 = 1'b1; #1;
    n_checks++; if ({bus.adFunc, bus.adaEn} !== {7'o51, 1'b1}) begin n_fail++; $display("FAIL ovf_setup: got f=%o en=%b expected f=51 en=1", bus.adFunc, bus.adaEn); end
    while (bus.done !== 1'b1 && cyc < MAX_CYC) begin
      if (bus.arLoad || bus.arxLoad || bus.mqSel != 2'b11) bad = 1'b1;
      tick(); cyc++;
    end
    if (bus.arLoad || bus.arxLoad || bus.mqSel != 2'b11) bad = 1'b1;
    bus.ADcarryM2 = 1'b0;
    pop_exp(e, ok);
    n_checks++; if (!ok || cyc !== e.lat) begin n_fail++; $display("FAIL ovf_latency: got %0d expected %0d", cyc, e.lat); end
    n_checks++; if (bus.divOverflow !== e.ovf) begin n_fail++; $display("FAIL ovf_flag: got %0b expected %0b", bus.divOverflow, e.ovf); end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL ovf_no_loads: got %0b expected 0", bad); end
    tick();
    n_checks++; if ({bus.busy, bus.divOverflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_sticky: got busy/ovf %b expected 01", {bus.busy, bus.divOverflow}); end
    start_op(1'b0, MUL_LAT, 1'b0);
    cyc = 1;
    n_checks++; if (bus.divOverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b expected 0", bus.divOverflow); end
    while (bus.done !== 1'b1 && cyc < MAX_CYC) begin tick(); cyc++; end
    pop_exp(e, ok);
    n_checks++; if (!ok || cyc !== e.lat) begin n_fail++; $display("FAIL ovf_next_latency: got %0d expected %0d", cyc, e.lat); end
    tick();
  endtask

  task automatic test_reset_mid();
    start_op(1'b0, MUL_LAT, 1'b0);
    repeat (5) tick();
    n_checks++; if (bus.stepCnt !== 6'd14) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 14", bus.stepCnt); end
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 00", {bus.busy, bus.done}); end
    n_checks++; if (bus.stepCnt !== 6'd0) begin n_fail++; $display("FAIL rstmid_cnt0: got %0d expected 0", bus.stepCnt); end
    n_checks++; if (ctl_vec() !== IDLE_VEC) begin n_fail++; $display("FAIL rstmid_codes: got %h expected %h", ctl_vec(), IDLE_VEC); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_contention();
    exp_t e; bit ok; int cyc;
    start_op(1'b0, MUL_LAT, 1'b0);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < MAX_CYC) begin
      bus.start = (cyc == 3 || cyc == 10 || cyc == 15);
      bus.opDiv = bus.start;
      tick(); cyc++;
    end
    bus.start = 1'b1;
    bus.opDiv = 1'b1;
    pop_exp(e, ok);
    n_checks++; if (!ok || cyc !== e.lat) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", cyc, e.lat); end
    n_checks++; if (bus.divOverflow !== e.ovf) begin n_fail++; $display("FAIL busy_start_ovf: got %0b expected %0b", bus.divOverflow, e.ovf); end
    tick();
    bus.start = 1'b0;
    bus.opDiv = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got busy %b expected 0", bus.busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    test_divide(1'b0);
    test_multiply();
    test_divide(1'b1);
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_multiply();
    test_booth_decode();
    test_divide(1'b1);
    test_div_overflow();
    test_reset_mid();
    test_contention();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
- Multiply/divide step sequencer that sits directly upstream of the EBOX data path and drives its AD function, ADA/ADB, AR/ARX and MQ/MQM selects and load strobes, one step per eboxClk.
- Reads back only MQ[34:35] and AD carry-out ADcarry[-2].
- Implements radix-4 Booth signed multiply (AR:MQ ← BR × MQ) and non-restoring divide (AR:ARX ÷ BR → MQ quotient, AR remainder).

Parameters:
MUL_STEPS, 18, Booth steps per multiply (2 multiplier bits per step)
DIV_STEPS, 36, quotient bits per divide

Ports:
eboxClk  in  1  EBOX clock, all state on rising edge
eboxReset_n  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
opDiv  in  1  0=multiply, 1=divide; sampled with start
MQ34  in  1  EDP_MQ[34]
MQ35  in  1  EDP_MQ[35]
ADcarryM2  in  1  EDP ADcarry[-2]
adFunc  out  7  AD function code (octal): 37=A, 06=A+B, 51=A-B, 34=0S
adaEn  out  1  ADA enable
adaSel  out  2  00=AR
adbSel  out  2  01=BR*2, 10=BR
arlSel, arrSel  out  3 each  010=AD, 101=AD*2, 111=AD/4
arLoad  out  1  load all AR halves
arxSel  out  3  drives both ARXL/ARXR selects; 101=ADX*2
arxLoad  out  1  ARX load
mqSel  out  2  00=LOAD, 01=SHL, 11=HOLD
mqmSel  out  2  00={ADX[34:35],MQ[0:33]}
mqmEn  out  1  MQM enable
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
divOverflow  out  1  sticky divide-overflow flag, cleared by next accepted start
stepCnt  out  6  remaining-step counter, diagnostic

Behaviour:
- Registered state: FSM, stepCnt, cbit (Booth carry), qbit (last quotient bit), opDiv latch, divOverflow. Control outputs are a combinational decode of these registers plus MQ34/MQ35/ADcarryM2.
- Reset, also mid-operation: async return to IDLE; stepCnt=0, cbit=0, qbit=0, divOverflow=0, busy=0, done=0. Control outputs take the IDLE codes.
- IDLE codes: adFunc=37, adaEn=0, adaSel=00, adbSel=10, all sel=010, arLoad=0, arxLoad=0, mqSel=11, mqmSel=00, mqmEn=0.
- IDLE: start=1 → SETUP. Latch opDiv, clear divOverflow. busy=1 in every state except IDLE.
- start while busy is ignored with no effect.
- SETUP, multiply:
  - adFunc=34, arLoad=1, arSel=010.
  - cbit←0, stepCnt←MUL_STEPS.
  - → MSTEP.
- SETUP, divide:
  - adaEn=1, adbSel=10, adFunc=51, no loads.
  - If ADcarryM2=1 (AR≥BR unsigned): divOverflow←1, → DONE.
  - Otherwise: stepCnt←DIV_STEPS, qbit←1, → DSTEP.
- MSTEP:
  - Booth digit {MQ34,MQ35,cbit}: 000/111 → adFunc 37; 001/010 → 06, adbSel 10; 011 → 06, adbSel 01; 100 → 51, adbSel 01; 101/110 → 51, adbSel 10.
  - adaEn=1, arLoad=1, arlSel=arrSel=111.
  - mqSel=00, mqmEn=1, mqmSel=00.
  - cbit←MQ34, stepCnt−1. stepCnt reaching 0 after this step → DONE.
- DSTEP:
  - adFunc = 51 if qbit=1, else 06; adbSel=10, adaEn=1, arLoad=1.
  - mqSel=01 shifts ADcarryM2 into MQ[35]; qbit←ADcarryM2; stepCnt−1.
  - Non-final step: arlSel=arrSel=101, arxSel=101, arxLoad=1.
  - Final step (stepCnt==1): arSel=010, arxLoad=0. → DFIX.
- DFIX: if qbit=0, adFunc=06, adbSel=10, arLoad=1, arSel=010 (restore remainder). Else no load. → DONE.
- DONE: done=1 for exactly one cycle, IDLE codes on outputs, → IDLE. busy drops the following cycle.
- Latency from the start edge:
  - multiply: DONE at cycle MUL_STEPS+2 = 20;
  - divide: DIV_STEPS+3 = 39;
  - overflow: 2.
- Caller's responsibility: BRX=0 during divide; AR holds the high dividend and ARX the low dividend.

Test Plan:
- Multiply, BR=3, MQ=5 → done at cycle 20; AR=0, MQ=15; 18 MSTEP cycles observed.
- Multiply, BR=−1 (777777777777), MQ=2 → AR=777777777777, MQ=777777777776 (−2).
- Booth decode: force MQ34=1, MQ35=1, cbit=0 in MSTEP → adFunc=51, adbSel=10. Force 011 → adFunc=06, adbSel=01.
- Divide, AR=0, ARX=100, BR=7 → done at cycle 39; MQ=14, AR=2, divOverflow=0.
- Divide overflow, AR=7, BR=7 → divOverflow=1 and done at cycle 2; arLoad, arxLoad and mqSel≠11 never asserted; next start clears the flag.
- Reset and contention:
  - eboxReset_n low at MSTEP step 5 → IDLE codes immediately, busy=0.
  - start pulsed while busy → no restart, completion cycle unchanged.
